// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types and constants for the instruction memory controller.
// Used by inst_mem_ctrl and inst_mem_array.
package inst_mem_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_DONE
  } state_t;

  // Even parity: the stored bit makes byte plus parity hold an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Byte-enable synchronous RAM with one write port and one registered read port.
// IMEM_PARITY_EN adds one even-parity bit per byte, checked on the read data.
module inst_mem_array
  import inst_mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata,
  output logic               parity_err
);

  localparam int unsigned NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

`ifdef IMEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rpar;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[b]) par_mem[waddr][b] <= byte_parity(wdata[b*8 +: 8]);
      end
    end
    if (re) rpar <= par_mem[raddr];
  end

  always_comb begin
    parity_err = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (byte_parity(rdata[b*8 +: 8]) != rpar[b]) parity_err = 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory: registered fetch port with valid/stall, loader write port,
// and RUN/DRAIN/LOAD/DONE boot FSM. Optional IMEM_PARITY_EN enables byte parity.
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter int unsigned     DEPTH     = 2048,
  parameter int unsigned     AW        = $clog2(DEPTH),
  parameter bit              BOOT_LOAD = 1'b1,
  parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [XLEN-1:0]   fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_data,
  output logic              fetch_err,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [XLEN-1:0]   ld_addr,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [XLEN/8-1:0] ld_be,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              load_mode
);

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DEPTH);

  state_t state, state_nxt;

  logic [XLEN-1:0] fetch_word, ld_word, rd_data;
  logic fetch_bad, ld_in_range, advance, ld_beat;
  logic use_ram, addr_err_q, parity_err;

  assign fetch_word  = fetch_addr >> 2;
  assign ld_word     = ld_addr >> 2;
  assign fetch_bad   = (fetch_addr[1:0] != 2'b00) || (fetch_word >= DEPTH_W);
  assign ld_in_range = ld_word < DEPTH_W;

  // The output register may advance unless it holds a valid word the IF stage is refusing.
  assign advance     = ~(fetch_valid & fetch_stall);
  assign fetch_ready = (state == ST_RUN) & fetch_req & advance;
  assign ld_beat     = ld_ready & ld_valid;
  assign load_mode   = (state == ST_LOAD) | (state == ST_DRAIN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (ld_start) state_nxt = ST_DRAIN;
      ST_DRAIN: if (advance) state_nxt = ST_LOAD;
      ST_LOAD:  if (ld_beat && ld_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT_LOAD ? ST_LOAD : ST_RUN;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      fetch_valid <= 1'b0;
      addr_err_q  <= 1'b0;
      use_ram     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ld_ready <= (state_nxt == ST_LOAD);
      ld_done  <= (state_nxt == ST_DONE);
      if (advance) begin
        fetch_valid <= fetch_ready;
        addr_err_q  <= fetch_ready & fetch_bad;
        use_ram     <= fetch_ready & ~fetch_bad;
      end
    end
  end

  // use_ram marks a valid in-range read, so stale RAM output never leaks to fetch_data.
  assign fetch_err  = addr_err_q | (use_ram & parity_err);
  assign fetch_data = (use_ram & ~parity_err) ? rd_data : NOP_WORD;

  inst_mem_array #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk        (clk),
    .we         (ld_beat & ld_in_range),
    .waddr      (ld_word[AW-1:0]),
    .wdata      (ld_data),
    .wbe        (ld_be),
    .re         (fetch_ready & ~fetch_bad),
    .raddr      (fetch_word[AW-1:0]),
    .rdata      (rd_data),
    .parity_err (parity_err)
  );

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed plus randomized bench for inst_mem_ctrl against a word-array reference model.
module tb_inst_mem_ctrl;
  import inst_mem_ctrl_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, fetch_stall, fetch_ready, fetch_valid, fetch_err;
  logic [31:0] fetch_addr, fetch_data;
  logic        ld_start, ld_valid, ld_last, ld_ready, ld_done, load_mode;
  logic [31:0] ld_addr, ld_data;
  logic [3:0]  ld_be;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model [DEPTH];

  inst_mem_ctrl #(
    .XLEN      (32),
    .DEPTH     (DEPTH),
    .BOOT_LOAD (1'b1),
    .NOP_WORD  (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_be       (ld_be),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .load_mode   (load_mode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if ((addr >> 2) < DEPTH)
      model[int'(addr >> 2)] = (model[int'(addr >> 2)] & ~mask) | (data & mask);
  endtask

  task automatic wait_ld_ready();
    for (int i = 0; i < 8 && ld_ready !== 1'b1; i++) tick();
    chk("ld_ready_wait", {31'b0, ld_ready}, 32'd1);
  endtask

  task automatic load_beat(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic last);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data; ld_be = be; ld_last = last;
    #1;
    chk("ld_ready_beat", {31'b0, ld_ready}, 32'd1);
    chk("ld_done_idle", {31'b0, ld_done}, 32'd0);
    tick();
    model_write(addr, data, be);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] addr);
    logic        exp_err;
    logic [31:0] exp_data;
    exp_err  = (addr % 4 != 0) || ((addr >> 2) >= DEPTH);
    exp_data = exp_err ? NOP : model[int'(addr >> 2)];
    fetch_req = 1'b1; fetch_addr = addr; fetch_stall = 1'b0;
    #1;
    chk({tag, "_ready"}, {31'b0, fetch_ready}, 32'd1);
    tick();
    chk({tag, "_valid"}, {31'b0, fetch_valid}, 32'd1);
    chk({tag, "_err"}, {31'b0, fetch_err}, {31'b0, exp_err});
    chk({tag, "_data"}, fetch_data, exp_data);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        flip;

    rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = '0; fetch_stall = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0; ld_last = 1'b0;
    #12;
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_data", fetch_data, NOP);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_ld_done", {31'b0, ld_done}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_load_mode", {31'b0, load_mode}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("boot_block", {31'b0, fetch_ready}, 32'd0);
      tick();
    end
    wait_ld_ready();

    // Boot image: four words, last beat flagged.
    for (int i = 0; i < 4; i++) load_beat(32'(4 * i), $urandom, 4'hF, i == 3);
    chk("done_pulse", {31'b0, ld_done}, 32'd1);
    chk("done_no_fetch", {31'b0, fetch_ready}, 32'd0);
    chk("done_ld_ready", {31'b0, ld_ready}, 32'd0);
    tick();
    chk("done_one_cycle", {31'b0, ld_done}, 32'd0);
    chk("run_load_mode", {31'b0, load_mode}, 32'd0);
    expect_fetch("fetch_boot", 32'h8);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'(4 * $urandom_range(0, 3) + $urandom_range(1, 3));
        1:       a = 32'(4 * $urandom_range(DEPTH, DEPTH + 100));
        default: a = 32'(4 * $urandom_range(0, 3));
      endcase
      expect_fetch("fetch_rand", a);
    end

    expect_fetch("stall_first", 32'h4);
    fetch_stall = 1'b1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", {31'b0, fetch_ready}, 32'd0);
      tick();
      chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
      chk("stall_hold", fetch_data, model[1]);
    end
    fetch_stall = 1'b0;
    #1;
    chk("stall_release_ready", {31'b0, fetch_ready}, 32'd1);
    tick();
    chk("stall_release_data", fetch_data, model[2]);

    expect_fetch("err_misaligned", 32'h6);
    expect_fetch("err_range", 32'(4 * DEPTH));
    fetch_req = 1'b0;
    tick();
    chk("bubble_valid", {31'b0, fetch_valid}, 32'd0);
    chk("bubble_err", {31'b0, fetch_err}, 32'd0);

    // ld_start while output is stalled: hold in DRAIN until the stall drops.
    expect_fetch("drain_pre", 32'h0);
    fetch_stall = 1'b1; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_mode", {31'b0, load_mode}, 32'd1);
      chk("drain_ld_ready", {31'b0, ld_ready}, 32'd0);
      chk("drain_ready", {31'b0, fetch_ready}, 32'd0);
      chk("drain_hold", fetch_data, model[0]);
      tick();
    end
    fetch_stall = 1'b0;
    tick();
    chk("drain_exit_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("drain_exit_mode", {31'b0, load_mode}, 32'd1);
    chk("drain_exit_valid", {31'b0, fetch_valid}, 32'd0);

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("ld_start_ignored", {31'b0, ld_ready}, 32'd1);

    load_beat(32'h10, $urandom, 4'hF, 1'b0);
    load_beat(32'h14, 32'h1122_3344, 4'hF, 1'b0);
    load_beat(32'h14, 32'hAABB_CCDD, 4'b0010, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) a = 32'(4 * (DEPTH + $urandom_range(0, 4)));
      else a = 32'(4 * $urandom_range(0, 4));
      load_beat(a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    load_beat(32'(4 * (DEPTH + 1)), $urandom, 4'hF, 1'b1);
    chk("done_pulse2", {31'b0, ld_done}, 32'd1);
    tick();
    for (int i = 0; i < 6; i++) expect_fetch("fetch_reload", 32'(4 * i));
    expect_fetch("be_fetch", 32'h14);
    chk("be_merge", fetch_data, 32'h1122_CC44);

    // ld_start with nothing pending still spends one cycle in DRAIN.
    fetch_req = 1'b0;
    tick();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("drain_min_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("drain_min_mode", {31'b0, load_mode}, 32'd1);
    tick();
    chk("drain_min_exit", {31'b0, ld_ready}, 32'd1);

    d = $urandom;
    load_beat(32'h0, d, 4'hF, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("midrst_mode", {31'b0, load_mode}, 32'd1);
    chk("midrst_valid", {31'b0, fetch_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wait_ld_ready();
    load_beat(32'h4, $urandom, 4'hF, 1'b1);
    chk("done_pulse3", {31'b0, ld_done}, 32'd1);
    tick();
    expect_fetch("partial_kept", 32'h0);

    flip = 1'b0;
`ifdef IMEM_PARITY_EN
    dut.u_array.par_mem[1][0] = ~dut.u_array.par_mem[1][0];
    flip = 1'b1;
`endif
    fetch_req = 1'b1; fetch_addr = 32'h4; fetch_stall = 1'b0;
    tick();
    chk("parity_valid", {31'b0, fetch_valid}, 32'd1);
    chk("parity_err", {31'b0, fetch_err}, {31'b0, flip});
    chk("parity_data", fetch_data, flip ? NOP : model[1]);
    fetch_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
